// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L1-to-L2 port arbiter.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  localparam int ARB_RR      = 0;
  localparam int ARB_FIXED_D = 1;

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational grant picker: round-robin on ties, or D-cache fixed priority.
module l2_arb_pick
  import l2_arb_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic       i_req,
  input  logic       d_req,
  input  requester_t last_grant,
  output logic       grant_valid,
  output requester_t grant_id
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = REQ_D;
    if (i_req && !d_req) begin
      grant_id = REQ_I;
    end else if (i_req && d_req) begin
      if (ARB_MODE == ARB_FIXED_D) grant_id = REQ_D;
      else grant_id = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the L1 I-cache and D-cache miss paths.
// The granted request is latched, so the L2 never sees live requester inputs.
//   state   | meaning
//   IDLE    | arbitrate between held requests, latch the winner
//   SERVE_I | L2 access on behalf of the I-cache, wait for mem_resp_l2
//   SERVE_D | L2 access on behalf of the D-cache, wait for mem_resp_l2
//   RECOVER | one quiet cycle so the winner can drop its held request
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_addr_l2,
  output logic              mem_read_l2,
  output logic              mem_write_l2,
  output logic [LINE_W-1:0] mem_wdata_l2,
  input  logic [LINE_W-1:0] mem_rdata_l2,
  input  logic              mem_resp_l2
);

  arb_state_t        state_q, state_d;
  requester_t        last_grant_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [LINE_W-1:0] lat_wdata_q;
  logic              lat_write_q;

  logic       i_req, d_req, grant_valid, serving;
  requester_t grant_id;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  l2_arb_pick #(.ARB_MODE(ARB_MODE)) u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_write_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_valid) begin
        last_grant_q <= grant_id;
        if (grant_id == REQ_D) begin
          lat_addr_q  <= d_addr;
          lat_wdata_q <= d_wdata;
          // write wins when d_read and d_write are raised together
          lat_write_q <= d_write;
        end else begin
          lat_addr_q  <= i_addr;
          lat_wdata_q <= '0;
          lat_write_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    serving      = 1'b0;
    mem_addr_l2  = '0;
    mem_wdata_l2 = '0;
    mem_read_l2  = 1'b0;
    mem_write_l2 = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    i_rdata      = '0;
    d_rdata      = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = (grant_id == REQ_D) ? SERVE_D : SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        serving = 1'b1;
        if (mem_resp_l2) state_d = RECOVER;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (serving) begin
      mem_addr_l2  = lat_addr_q;
      mem_wdata_l2 = lat_wdata_q;
      mem_read_l2  = ~lat_write_q;
      mem_write_l2 = lat_write_q;
    end
    // response steering is combinational: zero added latency on the return path
    if (state_q == SERVE_I && mem_resp_l2) begin
      i_resp  = 1'b1;
      i_rdata = mem_rdata_l2;
    end
    if (state_q == SERVE_D && mem_resp_l2) begin
      d_resp  = 1'b1;
      d_rdata = mem_rdata_l2;
    end
  end

  a_l2_op_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_read_l2 && mem_write_l2));
  a_resp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_resp && d_resp));
  a_resp_in_serve: assert property (@(posedge clk) disable iff (!rst_n)
    (i_resp || d_resp) |-> serving);

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench: round-robin arbiter (dut0) and fixed-priority arbiter (dut1),
// each with a small L2 model; completions are checked against a scoreboard.
module tb_l2_arbiter;

  typedef struct packed {
    logic         is_d;
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // dut0 (round-robin) signals
  logic [31:0]  i_addr0 = '0, d_addr0 = '0, mem_addr0;
  logic         i_read0 = 0, d_read0 = 0, d_write0 = 0;
  logic [255:0] d_wdata0 = '0, i_rdata0, d_rdata0, mem_wdata0;
  logic         i_resp0, d_resp0, mem_read0, mem_write0;
  logic [255:0] l2_rdata0;
  logic         l2_resp0;
  int           l2_cnt0, lat0 = 5;
  logic         use_pat0 = 0;
  logic [255:0] pat0 = '0;

  // dut1 (fixed priority) signals
  logic [31:0]  i_addr1 = '0, d_addr1 = '0, mem_addr1;
  logic         i_read1 = 0, d_read1 = 0, d_write1 = 0;
  logic [255:0] d_wdata1 = '0, i_rdata1, d_rdata1, mem_wdata1;
  logic         i_resp1, d_resp1, mem_read1, mem_write1;
  logic [255:0] l2_rdata1;
  logic         l2_resp1;
  int           l2_cnt1, lat1 = 2;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t m0, m1;

  l2_arbiter #(.ADDR_W(32), .LINE_W(256), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr0), .i_read(i_read0), .i_rdata(i_rdata0), .i_resp(i_resp0),
    .d_addr(d_addr0), .d_read(d_read0), .d_write(d_write0), .d_wdata(d_wdata0),
    .d_rdata(d_rdata0), .d_resp(d_resp0),
    .mem_addr_l2(mem_addr0), .mem_read_l2(mem_read0), .mem_write_l2(mem_write0),
    .mem_wdata_l2(mem_wdata0), .mem_rdata_l2(l2_rdata0), .mem_resp_l2(l2_resp0)
  );

  l2_arbiter #(.ADDR_W(32), .LINE_W(256), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr1), .i_read(i_read1), .i_rdata(i_rdata1), .i_resp(i_resp1),
    .d_addr(d_addr1), .d_read(d_read1), .d_write(d_write1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_resp(d_resp1),
    .mem_addr_l2(mem_addr1), .mem_read_l2(mem_read1), .mem_write_l2(mem_write1),
    .mem_wdata_l2(mem_wdata1), .mem_rdata_l2(l2_rdata1), .mem_resp_l2(l2_resp1)
  );

  // L2 models: pulse resp in the lat-th cycle of a held request; data = addr replicated
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l2_resp0 <= 1'b0; l2_cnt0 <= 0; l2_rdata0 <= '0;
    end else if (l2_resp0) begin
      l2_resp0 <= 1'b0; l2_cnt0 <= 0; l2_rdata0 <= '0;
    end else if (mem_read0 || mem_write0) begin
      if (l2_cnt0 >= lat0 - 2) begin
        l2_resp0  <= 1'b1;
        l2_rdata0 <= use_pat0 ? pat0 : {8{mem_addr0}};
      end else l2_cnt0 <= l2_cnt0 + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l2_resp1 <= 1'b0; l2_cnt1 <= 0; l2_rdata1 <= '0;
    end else if (l2_resp1) begin
      l2_resp1 <= 1'b0; l2_cnt1 <= 0; l2_rdata1 <= '0;
    end else if (mem_read1 || mem_write1) begin
      if (l2_cnt1 >= lat1 - 2) begin
        l2_resp1  <= 1'b1;
        l2_rdata1 <= {8{mem_addr1}};
      end else l2_cnt1 <= l2_cnt1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic is_d, input logic [31:0] a, input logic wr,
                              input logic [255:0] wd, input logic [255:0] rd);
    exp_t e;
    e.is_d = is_d; e.addr = a; e.wr = wr; e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  // scoreboard monitors: compare every completion against the next expected entry
  always @(negedge clk) begin
    if (rst_n && (i_resp0 || d_resp0)) begin
      chk("dut0_sb_avail", 256'(sb0.size() != 0), 256'd1);
      if (sb0.size() != 0) begin
        m0 = sb0.pop_front();
        chk("dut0_who_d", d_resp0, m0.is_d);
        chk("dut0_who_i", i_resp0, !m0.is_d);
        chk("dut0_i_rdata", i_rdata0, m0.is_d ? 256'd0 : m0.rdata);
        chk("dut0_d_rdata", d_rdata0, m0.is_d ? m0.rdata : 256'd0);
        chk("dut0_addr", mem_addr0, m0.addr);
        chk("dut0_write", mem_write0, m0.wr);
        chk("dut0_read", mem_read0, !m0.wr);
        if (m0.wr) chk("dut0_wdata", mem_wdata0, m0.wdata);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (i_resp1 || d_resp1)) begin
      chk("dut1_sb_avail", 256'(sb1.size() != 0), 256'd1);
      if (sb1.size() != 0) begin
        m1 = sb1.pop_front();
        chk("dut1_who_d", d_resp1, m1.is_d);
        chk("dut1_who_i", i_resp1, !m1.is_d);
        chk("dut1_i_rdata", i_rdata1, m1.is_d ? 256'd0 : m1.rdata);
        chk("dut1_d_rdata", d_rdata1, m1.is_d ? m1.rdata : 256'd0);
        chk("dut1_addr", mem_addr1, m1.addr);
      end
    end
  end

  // waits for n completions on one dut, counting cycles with an L2 op active
  task automatic wait_resp(input bit which, input int n, output int cyc);
    int got;
    got = 0;
    cyc = 0;
    for (int k = 0; k < 300 && got < n; k++) begin
      @(negedge clk);
      if (which == 1'b0) begin
        if (mem_read0 || mem_write0) cyc++;
        if (i_resp0 || d_resp0) got++;
      end else begin
        if (mem_read1 || mem_write1) cyc++;
        if (i_resp1 || d_resp1) got++;
      end
    end
    chk("wait_resp_timeout", 256'(got), 256'(n));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cyc;

  initial begin
    // reset values
    #12;
    chk("rst_mem_read", mem_read0, 1'b0);
    chk("rst_mem_write", mem_write0, 1'b0);
    chk("rst_i_resp", i_resp0, 1'b0);
    chk("rst_d_resp", d_resp0, 1'b0);
    chk("rst_mem_addr", mem_addr0, 32'd0);
    chk("rst_mem_wdata", mem_wdata0, 256'd0);
    chk("rst_i_rdata", i_rdata0, 256'd0);
    chk("rst_d_rdata", d_rdata0, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // I-only read, 5-cycle L2 latency, fixed pattern data
    lat0 = 5; use_pat0 = 1'b1; pat0 = {32{8'hA5}};
    i_addr0 = 32'h0000_1000; i_read0 = 1'b1;
    sb0.push_back(mk(1'b0, 32'h0000_1000, 1'b0, 256'd0, {32{8'hA5}}));
    @(negedge clk);
    chk("i_read_not_yet_on_l2", mem_read0, 1'b0);
    wait_resp(1'b0, 1, cyc);
    chk("i_read_l2_cycles", 256'(cyc), 256'd5);
    step(); i_read0 = 1'b0; use_pat0 = 1'b0;
    step();

    // D writeback
    lat0 = 3;
    d_addr0 = 32'h8000_0040; d_wdata0 = 256'h1234; d_write0 = 1'b1;
    sb0.push_back(mk(1'b1, 32'h8000_0040, 1'b1, 256'h1234, {8{32'h8000_0040}}));
    wait_resp(1'b0, 1, cyc);
    chk("d_write_l2_cycles", 256'(cyc), 256'd3);
    step(); d_write0 = 1'b0;
    step();

    // read+write together is a write; live address changes must not leak to L2
    lat0 = 4;
    d_addr0 = 32'h0000_2200; d_wdata0 = 256'hBEEF; d_read0 = 1'b1; d_write0 = 1'b1;
    sb0.push_back(mk(1'b1, 32'h0000_2200, 1'b1, 256'hBEEF, {8{32'h0000_2200}}));
    step(); step();
    d_addr0 = 32'h0000_3300; d_wdata0 = 256'hDEAD;
    wait_resp(1'b0, 1, cyc);
    chk("rw_l2_cycles", 256'(cyc), 256'd3);
    step(); d_read0 = 1'b0; d_write0 = 1'b0;

    // fresh reset so D wins the first tie, then both held: D, I, D, I
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    lat0 = 2;
    i_addr0 = 32'h0000_0100; d_addr0 = 32'h0000_0200; d_wdata0 = '0;
    i_read0 = 1'b1; d_read0 = 1'b1;
    for (int t = 0; t < 2; t++) begin
      sb0.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 256'd0, {8{32'h0000_0200}}));
      sb0.push_back(mk(1'b0, 32'h0000_0100, 1'b0, 256'd0, {8{32'h0000_0100}}));
    end
    wait_resp(1'b0, 4, cyc);
    chk("rr_l2_cycles", 256'(cyc), 256'd8);
    step(); i_read0 = 1'b0; d_read0 = 1'b0;
    step();

    // fixed priority: D wins while held, I only once D drops
    i_addr1 = 32'h0000_0A00; d_addr1 = 32'h0000_0B00;
    i_read1 = 1'b1; d_read1 = 1'b1;
    for (int t = 0; t < 3; t++)
      sb1.push_back(mk(1'b1, 32'h0000_0B00, 1'b0, 256'd0, {8{32'h0000_0B00}}));
    sb1.push_back(mk(1'b0, 32'h0000_0A00, 1'b0, 256'd0, {8{32'h0000_0A00}}));
    wait_resp(1'b1, 3, cyc);
    step(); d_read1 = 1'b0;
    wait_resp(1'b1, 1, cyc);
    step(); i_read1 = 1'b0;
    step();

    // reset in the middle of SERVE_I
    lat0 = 5;
    i_addr0 = 32'h0000_4440; i_read0 = 1'b1;
    step(); step();
    chk("mid_serve_read_active", mem_read0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_read", mem_read0, 1'b0);
    chk("async_rst_mem_addr", mem_addr0, 32'd0);
    chk("async_rst_i_resp", i_resp0, 1'b0);
    chk("async_rst_i_rdata", i_rdata0, 256'd0);
    i_read0 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    i_addr0 = 32'h0000_5500; i_read0 = 1'b1;
    sb0.push_back(mk(1'b0, 32'h0000_5500, 1'b0, 256'd0, {8{32'h0000_5500}}));
    @(negedge clk);
    chk("post_rst_not_yet_on_l2", mem_read0, 1'b0);
    wait_resp(1'b0, 1, cyc);
    chk("post_rst_l2_cycles", 256'(cyc), 256'd5);
    step(); i_read0 = 1'b0;
    step(); step();

    chk("sb0_drained", 256'(sb0.size()), 256'd0);
    chk("sb1_drained", 256'(sb1.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
